dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory (dmem: comb. read, sync. write) between the
//  processor load/store port (m0, single beat) and a secondary master (m1:
//  loader/DMA, bursts). Sits between processor/dmem in top; stalls m0 while m1 owns dmem.
//  Registered-grant FSM, round-robin arbitration, burst address generation.
// PARAMETERS
//  AW        32  address width
//  DW        32  data width
//  MAX_BURST 16  max m1 beats per burst; LW = $clog2(MAX_BURST)
// PORTS
//  clk        in   1   clock, all state on rising edge
//  rst        in   1   asynchronous, active-low reset
//  m0_req     in   1   processor access request, held until m0_gnt
//  m0_we      in   1   processor write enable
//  m0_addr    in   AW  processor byte address
//  m0_wdata   in   DW  processor write data
//  m0_gnt     out  1   transfer occurs this cycle
//  m0_rdata   out  DW  read data, valid when m0_gnt
//  m0_stall   out  1   m0_req & ~m0_gnt (processor hold)
//  m1_req     in   1   burst request, held high for whole burst
//  m1_we      in   1   burst direction, sampled at grant
//  m1_addr    in   AW  burst start address, sampled at grant
//  m1_len     in   LW  beats-1, sampled at grant
//  m1_wdata   in   DW  write data; next beat presented after each m1_gnt
//  m1_gnt     out  1   one beat transfers this cycle
//  m1_rdata   out  DW  read data, valid when m1_gnt
//  mem_we     out  1   to dmem we
//  mem_addr   out  AW  to dmem a
//  mem_wdata  out  DW  to dmem wd
//  mem_rdata  in   DW  from dmem rd
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE, beat=0, last=1; m0_gnt=m1_gnt=0,
//    mem_we=0, mem_addr=0, mem_wdata=0. Reset mid-burst aborts, no further beats.
//  - States IDLE, OWN0, OWN1. Grants are decoded from registered state only.
//  - IDLE: no grant, mem_* driven 0. Only m0_req -> OWN0; only m1_req -> OWN1;
//    both -> port != last. Winner recorded in last. m1 regs (we,addr,len) load
//    on IDLE->OWN1. Latency req->gnt = 1 cycle.
//  - OWN0: m0_gnt=1 one cycle; mem_* = m0_*; next state IDLE unconditionally.
//  - OWN1: m1_gnt=1 each cycle while m1_req=1; mem_addr = addr_r + 4*beat
//    (mod 2^AW, wraps); mem_we = we_r; mem_wdata = m1_wdata. beat==len_r ->
//    IDLE, beat<=0; else beat++. m1_req=0 in OWN1 -> abort: m1_gnt=0, mem_we=0
//    that cycle, IDLE next, beat<=0.
//  - Every transaction returns to IDLE: one bubble cycle between transactions;
//    m0 max one access per 2 cycles.
//  - m0_rdata = m1_rdata = mem_rdata (broadcast); meaningful only with own gnt.
//  - Requests arriving during OWN1 wait; no preemption of a burst.
//  - m0_addr/m1_addr low bits passed unchanged; alignment is requester's duty.
// CONFIGURATION
//  DMEM_ARB_FIXED_PRIO_EN defined: IDLE tie always grants m0; last unused.
//  Undefined (default): round-robin per IDLE rule above.
// TESTING
//  1 m0 write 0xDEADBEEF @0x64, req at t: m0_gnt=1, mem_we=1, mem_addr=0x64 at
//    t+1; m0_stall=1 at t, 0 at t+1; gnt=0 at t+2; read back returns 0xDEADBEEF.
//  2 m0,m1 tie from reset, m1_len=0: m0 granted t+1, IDLE t+2, m1 t+3; next
//    tie grants m0 (m1 again under DMEM_ARB_FIXED_PRIO_EN? no: m0 always).
//  3 m1 write burst @0x100 len=3: mem_addr 0x100,0x104,0x108,0x10C on 4
//    consecutive cycles; m0_req raised mid-burst stalls, granted 2 cycles after last beat.
//  4 m1 burst @0xFFFFFFFC len=1: beats at 0xFFFFFFFC then 0x00000000.
//  5 m1_req dropped after beat 1 of len=7: no beat 2 (mem_we=0), IDLE next;
//    rst=0 mid-burst: gnt/mem_we drop immediately, next tie after release -> m0.
//  6 FIXED_PRIO_EN build: 3 consecutive ties -> m0 granted each time, m1 starves.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: processor port m0, burst master m1 and the dmem side.
// slave = the arbiter's view; master = the environment (requesters plus memory).
interface dmem_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int LW = 4
);
   logic          m0_req;
   logic          m0_we;
   logic [AW-1:0] m0_addr;
   logic [DW-1:0] m0_wdata;
   logic          m0_gnt;
   logic [DW-1:0] m0_rdata;
   logic          m0_stall;

   logic          m1_req;
   logic          m1_we;
   logic [AW-1:0] m1_addr;
   logic [LW-1:0] m1_len;
   logic [DW-1:0] m1_wdata;
   logic          m1_gnt;
   logic [DW-1:0] m1_rdata;

   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata,
      output m0_gnt, m0_rdata, m0_stall,
      input  m1_req, m1_we, m1_addr, m1_len, m1_wdata,
      output m1_gnt, m1_rdata,
      output mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata,
      input  m0_gnt, m0_rdata, m0_stall,
      output m1_req, m1_we, m1_addr, m1_len, m1_wdata,
      input  m1_gnt, m1_rdata,
      input  mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port dmem between processor port m0 and burst master m1.
// Ties are round-robin by default; define DMEM_ARB_FIXED_PRIO_EN to always favour m0.
module dmem_arbiter #(
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter int MAX_BURST = 16,
   parameter int LW        = $clog2(MAX_BURST)
) (
   input  logic          clk,
   input  logic          rst,
   dmem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [LW-1:0] r_beat;
   logic [LW-1:0] w_beat_nxt;
   logic          r_m1_we;
   logic [AW-1:0] r_m1_addr;
   logic [LW-1:0] r_m1_len;
   logic          w_any_req;
   logic          w_pick_m1;
   logic          w_load_m1;
   logic [AW-1:0] w_burst_addr;

   assign w_any_req = bus.m0_req | bus.m1_req;

`ifdef DMEM_ARB_FIXED_PRIO_EN
   assign w_pick_m1 = bus.m1_req & ~bus.m0_req;
`else
   logic r_last;  // 1 = m1 won the most recent arbitration

   // On a tie the port that did not win last time goes first.
   assign w_pick_m1 = bus.m1_req & (~bus.m0_req | ~r_last);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_last <= 1'b1;
      else if (r_state == IDLE && w_any_req)
         r_last <= w_pick_m1;
   end
`endif

   // Word-stepped burst address; wraps modulo 2^AW.
   assign w_burst_addr = r_m1_addr + AW'({r_beat, 2'b00});

   // NOTE: the asynchronous reset forces IDLE immediately, so grants and mem_we drop
   // without waiting for a clock edge; sequential state is updated with <= only.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_beat  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_beat  <= w_beat_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_m1_we   <= 1'b0;
         r_m1_addr <= '0;
         r_m1_len  <= '0;
      end else if (w_load_m1) begin
         r_m1_we   <= bus.m1_we;
         r_m1_addr <= bus.m1_addr;
         r_m1_len  <= bus.m1_len;
      end
   end

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt   = r_state;
      w_beat_nxt    = r_beat;
      w_load_m1     = 1'b0;
      bus.m0_gnt    = 1'b0;
      bus.m1_gnt    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;

      case (r_state)
         IDLE: begin
            if (w_any_req) begin
               if (w_pick_m1) begin
                  w_state_nxt = OWN1;
                  w_load_m1   = 1'b1;
               end else begin
                  w_state_nxt = OWN0;
               end
            end
         end

         OWN0: begin
            bus.m0_gnt    = 1'b1;
            bus.mem_we    = bus.m0_we;
            bus.mem_addr  = bus.m0_addr;
            bus.mem_wdata = bus.m0_wdata;
            w_state_nxt   = IDLE;
         end

         OWN1: begin
            bus.mem_addr  = w_burst_addr;
            bus.mem_wdata = bus.m1_wdata;
            if (bus.m1_req) begin
               bus.m1_gnt = 1'b1;
               bus.mem_we = r_m1_we;
               if (r_beat == r_m1_len) begin
                  w_state_nxt = IDLE;
                  w_beat_nxt  = '0;
               end else begin
                  w_beat_nxt  = r_beat + 1'b1;
               end
            end else begin
               // Requester withdrew mid-burst: no transfer this cycle, burst ends.
               w_state_nxt = IDLE;
               w_beat_nxt  = '0;
            end
         end

         default: begin
            w_state_nxt = IDLE;
            w_beat_nxt  = '0;
         end
      endcase
   end

   assign bus.m0_rdata = bus.mem_rdata;
   assign bus.m1_rdata = bus.mem_rdata;
   assign bus.m0_stall = bus.m0_req & ~bus.m0_gnt;

endmodule
